hazard_scoreboard: RTL
======================

Name: hazard_scoreboard

Overview:
- Parametrised hazard-detection and forwarding-control unit for the pipelined WISC core.
- Tracks in-flight register writes across a configurable number of post-decode stages and raises stall/bubble signals.
- Produces operand forwarding selects.
- Manages a multi-cycle IF/ID flush after taken control transfers; counts stall cycles for performance debug.

Parameters:
- REG_AW, 4, register address width; address 0 is hardwired zero and never creates a hazard.
- DEPTH, 3, tracked stages after ID (entry 0 = EX, entry DEPTH-1 = WB); legal range 2..7.
- FWD_EN, 1, 1 = forwarding mode; 0 = stall-only mode.
- RF_BYPASS, 1, 1 = register file writes before read in the same cycle, so WB entry never hazards.
- FLUSH_CYCLES, 1, number of cycles IF/ID is flushed per taken transfer; legal range 1..3.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  synchronous reset, active-high.
- hlt  in  1  freeze: no shift, no counter change.
- id_rs1  in  REG_AW  source A address.
- id_rs1_used  in  1  source A is read.
- id_rs2  in  REG_AW  source B address.
- id_rs2_used  in  1  source B is read.
- id_wr_en  in  1  ID instruction writes a register.
- id_wr_dst  in  REG_AW  ID destination.
- id_is_load  in  1  ID instruction is a load; result is valid only from entry 1 onward.
- branch_taken  in  1  taken branch/call/ret resolved in ID.
- stall  out  1  hold PC and IF/ID.
- bubble  out  1  clear ID/EX; equals stall.
- flush_if_id  out  1  clear IF/ID.
- fwd_sel_a  out  FSW  source A select, FSW = $clog2(DEPTH+1).
- fwd_sel_b  out  FSW  source B select.
- stall_count  out  16  saturating count of stall cycles.

Behaviour:
- State is a scoreboard of DEPTH entries, each {valid, dst, is_load}, plus flush_cnt and stall_count.
- Reset (rst=1 at edge): all entries invalid, flush_cnt=0, stall_count=0.
  - While rst is high, all outputs are forced to 0 combinationally.
- Match rule for a source:
  - A source matches entry k when used=1, addr!=0, entry valid, and entry dst==addr.
  - The tracked range is k in 0..DEPTH-1, or 0..DEPTH-2 when RF_BYPASS=1.
- Stall, FWD_EN=0: asserted if either source matches any entry in the tracked range.
- Stall, FWD_EN=1: asserted only if the youngest matching entry for either source is entry 0 with is_load=1 (load-use).
- Forward select, FWD_EN=1:
  - fwd_sel = k+1 for the youngest (lowest k) matching entry in the tracked range; 0 = register file.
  - fwd_sel is forced 0 whenever stall=1.
- Forward select, FWD_EN=0: fwd_sel is always 0.
- Shift, when hlt=0 on each edge:
  - entry[k+1] <= entry[k]; entry DEPTH-1 retires.
  - entry[0] <= {id_wr_en & ~stall & ~flush_if_id, id_wr_dst, id_is_load}.
  - id_wr_en from a stalled or flushed ID slot enters as a bubble (valid=0).
- Flush:
  - flush_if_id = (branch_taken & ~stall) | (flush_cnt != 0).
  - On an edge with branch_taken & ~stall & ~hlt, flush_cnt <= FLUSH_CYCLES-1; otherwise it decrements toward 0 when nonzero and hlt=0.
  - branch_taken while stall=1 is ignored: branch operands are not ready, and the branch re-presents next cycle.
  - branch_taken while flush_cnt!=0 is ignored: that slot is being squashed.
- stall_count: increments on each edge with stall=1 and hlt=0; saturates at 16'hFFFF with no wrap.
- hlt=1: scoreboard, flush_cnt and stall_count hold; outputs are still computed from held state.
- Reset mid-flush or mid-stall clears all state the same edge.
- Stall and flush are independent; both may be high in the same cycle only via flush_cnt!=0.

Test Plan:
- Reset: assert rst 2 cycles with id_rs1_used=1, id_rs1=3 -> stall=0, flush_if_id=0, fwd_sel_a=0, stall_count=0; after release, scoreboard is empty and still no stall.
- Forwarding (FWD_EN=1, DEPTH=3), EX/MEM path:
  - ADD R3 (wr_en, dst=3), then next cycle rs1=3 -> stall=0, fwd_sel_a=1.
  - One idle cycle later, same read -> fwd_sel_a=2.
  - With RF_BYPASS=1, a third cycle later -> fwd_sel_a=0.
- Load-use: LW R5, then next cycle rs2=5 -> stall=1 and bubble=1 for exactly one cycle, stall_count=1; next cycle stall=0, fwd_sel_b=2.
- Stall-only mode (FWD_EN=0, RF_BYPASS=1, DEPTH=3): write R4 then read R4 -> stall for 2 cycles, then release with fwd_sel=0; R0 write/read never stalls.
- Flush (FLUSH_CYCLES=2): branch_taken pulse -> flush_if_id high for 2 consecutive cycles; branch_taken during an active stall -> no flush until stall drops.
- Saturation/hlt: preload stall_count near 16'hFFFF via a long load-use hold -> holds at FFFF; hlt=1 during a stall -> stall_count and scoreboard unchanged.

Source files
------------

// File: rtl/hazard_scoreboard.sv
// Hazard scoreboard for the WISC pipeline: tracks in-flight register writes after ID,
// raises stall/bubble, picks operand forwarding sources and sequences IF/ID flushes.
module hazard_scoreboard #(
  parameter int REG_AW       = 4,
  parameter int DEPTH        = 3,
  parameter int FWD_EN       = 1,
  parameter int RF_BYPASS    = 1,
  parameter int FLUSH_CYCLES = 1,
  localparam int FSW         = $clog2(DEPTH + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              hlt,
  input  logic [REG_AW-1:0] id_rs1,
  input  logic              id_rs1_used,
  input  logic [REG_AW-1:0] id_rs2,
  input  logic              id_rs2_used,
  input  logic              id_wr_en,
  input  logic [REG_AW-1:0] id_wr_dst,
  input  logic              id_is_load,
  input  logic              branch_taken,
  output logic              stall,
  output logic              bubble,
  output logic              flush_if_id,
  output logic [FSW-1:0]    fwd_sel_a,
  output logic [FSW-1:0]    fwd_sel_b,
  output logic [15:0]       stall_count
);

  localparam int NTRK = (RF_BYPASS != 0) ? DEPTH - 1 : DEPTH;

  logic [DEPTH-1:0]  r_vld;
  logic [REG_AW-1:0] r_dst [DEPTH];
  // Only the EX entry's load flag can produce a load-use stall, so older ones are not kept.
  logic              r_ld0;
  logic [1:0]        r_flush_cnt;
  logic [15:0]       r_stall_cnt;

  logic              w_hit_a, w_hit_b;
  logic [FSW-1:0]    w_idx_a, w_idx_b;
  logic              w_stall, w_flush;
  logic [FSW-1:0]    w_sel_a, w_sel_b;

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  // Youngest match wins: scan oldest to youngest so the lowest index is written last.
  always_comb begin
    w_hit_a = 1'b0;
    w_idx_a = '0;
    w_hit_b = 1'b0;
    w_idx_b = '0;
    for (int k = DEPTH - 1; k >= 0; k--) begin
      if (k < NTRK && r_vld[k]) begin
        if (id_rs1_used && id_rs1 != '0 && r_dst[k] == id_rs1) begin
          w_hit_a = 1'b1;
          w_idx_a = FSW'(k);
        end
        if (id_rs2_used && id_rs2 != '0 && r_dst[k] == id_rs2) begin
          w_hit_b = 1'b1;
          w_idx_b = FSW'(k);
        end
      end
    end
  end

  always_comb begin
    if (FWD_EN != 0)
      w_stall = r_ld0 && ((w_hit_a && w_idx_a == '0) || (w_hit_b && w_idx_b == '0));
    else
      w_stall = w_hit_a || w_hit_b;
    w_flush = (branch_taken && !w_stall) || (r_flush_cnt != 2'd0);
    w_sel_a = (FWD_EN != 0 && w_hit_a && !w_stall) ? w_idx_a + FSW'(1) : '0;
    w_sel_b = (FWD_EN != 0 && w_hit_b && !w_stall) ? w_idx_b + FSW'(1) : '0;
  end

  assign stall       = w_stall & ~rst;
  assign bubble      = w_stall & ~rst;
  assign flush_if_id = w_flush & ~rst;
  assign fwd_sel_a   = rst ? '0 : w_sel_a;
  assign fwd_sel_b   = rst ? '0 : w_sel_b;
  assign stall_count = rst ? 16'd0 : r_stall_cnt;

  // Control state: valid bits, flush sequencer, stall counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_vld       <= '0;
      r_flush_cnt <= 2'd0;
      r_stall_cnt <= 16'd0;
    end else if (!hlt) begin
      r_vld <= {r_vld[DEPTH-2:0], id_wr_en & ~w_stall & ~w_flush};
      if (branch_taken && !w_stall && r_flush_cnt == 2'd0)
        r_flush_cnt <= 2'(FLUSH_CYCLES - 1);
      else if (r_flush_cnt != 2'd0)
        r_flush_cnt <= r_flush_cnt - 2'd1;
      if (w_stall)
        r_stall_cnt <= sat_inc16(r_stall_cnt);
    end
  end

  // Entry payload: meaningful only where the matching valid bit is set.
  always_ff @(posedge clk) begin
    if (!hlt) begin
      r_ld0    <= id_is_load;
      r_dst[0] <= id_wr_dst;
      for (int k = 1; k < DEPTH; k++)
        r_dst[k] <= r_dst[k-1];
    end
  end

endmodule
